// File: rtl/sequence_acceptor.sv
// Key-sequence acceptor: detects key releases, matches them against a
// programmable code of up to MAX_LEN entries, and reports accept/reject.
module sequence_acceptor #(
  parameter int NUM_KEYS  = 4,
  parameter int MAX_LEN   = 16,
  parameter int TIMEOUT_W = 25,
  localparam int KW = $clog2(NUM_KEYS),
  localparam int LW = $clog2(MAX_LEN + 1),
  localparam int AW = $clog2(MAX_LEN)
) (
  input  logic                clk,
  input  logic                reset_,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                prog_we,
  input  logic [AW-1:0]       prog_addr,
  input  logic [KW-1:0]       prog_key,
  input  logic                len_we,
  input  logic [LW-1:0]       len_val,
  output logic [1:0]          state,
  output logic [LW-1:0]       progress,
  output logic                accept_pulse,
  output logic                reject_pulse,
  output logic [3:0]          fail_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MATCH  = 2'd1,
    S_ACCEPT = 2'd2,
    S_REJECT = 2'd3
  } state_e;

  localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);

  state_e                 state_q, state_d;
  logic [LW-1:0]          progress_q, progress_d;
  logic [LW-1:0]          len_q;
  logic [TIMEOUT_W-1:0]   tmr_q, tmr_d;
  logic [1:0]             hist_q [NUM_KEYS];
  logic [KW-1:0]          seq_q [MAX_LEN];
  logic                   accept_q, reject_q;
  logic [3:0]             fail_q;

  logic                   any_rel, multi_rel, valid_ev, timeout_hit;
  logic [KW-1:0]          rel_idx;
  logic [KW-1:0]          exp_key;

  // Release decode: a key whose history reads 2'b10 was released this cycle.
  always_comb begin
    any_rel   = 1'b0;
    multi_rel = 1'b0;
    rel_idx   = '0;
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      if (hist_q[k] == 2'b10) begin
        multi_rel = multi_rel | any_rel;
        any_rel   = 1'b1;
        rel_idx   = KW'(k);
      end
    end
    valid_ev    = any_rel & ~multi_rel;
    timeout_hit = &tmr_q;
    exp_key     = seq_q[progress_q[AW-1:0]];
  end

  always_comb begin
    state_d    = state_q;
    progress_d = progress_q;
    case (state_q)
      S_IDLE: begin
        if (len_q != '0 && valid_ev && rel_idx == seq_q[0]) begin
          progress_d = LW'(1);
          state_d    = (len_q == LW'(1)) ? S_ACCEPT : S_MATCH;
        end
      end
      S_MATCH: begin
        // A release in the same cycle as the timeout wins over the timeout.
        if (any_rel) begin
          if (valid_ev && rel_idx == exp_key) begin
            progress_d = progress_q + LW'(1);
            if (progress_d == len_q) state_d = S_ACCEPT;
          end else begin
            state_d = S_REJECT;
          end
        end else if (timeout_hit) begin
          state_d = S_REJECT;
        end
      end
      default: begin
        if (any_rel) begin
          state_d    = S_IDLE;
          progress_d = '0;
        end
      end
    endcase

    if (any_rel || state_d != S_MATCH) tmr_d = '0;
    else if (timeout_hit)              tmr_d = tmr_q;
    else                               tmr_d = tmr_q + TIMEOUT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= S_IDLE;
      progress_q <= '0;
      len_q      <= '0;
      tmr_q      <= '0;
      accept_q   <= 1'b0;
      reject_q   <= 1'b0;
      fail_q     <= '0;
      for (int unsigned k = 0; k < NUM_KEYS; k++) hist_q[k] <= '0;
      for (int unsigned i = 0; i < MAX_LEN; i++)  seq_q[i]  <= '0;
    end else begin
      state_q    <= state_d;
      progress_q <= progress_d;
      tmr_q      <= tmr_d;
      for (int unsigned k = 0; k < NUM_KEYS; k++) hist_q[k] <= {hist_q[k][0], keys[k]};

      // Writes look at the registered state, so a write coinciding with the
      // IDLE->MATCH edge still lands and is seen by the next comparison.
      if (state_q == S_IDLE) begin
        if (prog_we) seq_q[prog_addr] <= prog_key;
        if (len_we)  len_q <= (len_val > MAX_LEN_L) ? MAX_LEN_L : len_val;
      end

      accept_q <= (state_d == S_ACCEPT) && (state_q != S_ACCEPT);
      reject_q <= (state_d == S_REJECT) && (state_q != S_REJECT);

      if (state_d == S_ACCEPT && state_q != S_ACCEPT) begin
        fail_q <= '0;
      end else if (state_d == S_REJECT && state_q != S_REJECT && fail_q != 4'hF) begin
        fail_q <= fail_q + 4'd1;
      end
    end
  end

  assign state        = state_q;
  assign progress     = progress_q;
  assign accept_pulse = accept_q;
  assign reject_pulse = reject_q;
  assign fail_count   = fail_q;

endmodule

// File: tb/tb_sequence_acceptor.sv
// Directed bench for sequence_acceptor: accept/reject pulses are checked
// through an expectation queue, state/progress through immediate checks.
module tb_sequence_acceptor;

  logic       clk = 1'b0;
  logic       reset_;
  logic [3:0] keys;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [1:0] prog_key;
  logic       len_we;
  logic [4:0] len_val;
  logic [1:0] state;
  logic [4:0] progress;
  logic       accept_pulse;
  logic       reject_pulse;
  logic [3:0] fail_count;

  int passed = 0;
  int total  = 0;

  typedef struct {
    bit acc;
    int prog;
    int fail;
  } exp_t;
  exp_t sb_q[$];

  int code [16] = '{0, 0, 1, 1, 2, 3, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};

  sequence_acceptor #(
    .NUM_KEYS (4),
    .MAX_LEN  (16),
    .TIMEOUT_W(4)
  ) dut (
    .clk         (clk),
    .reset_      (reset_),
    .keys        (keys),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_key    (prog_key),
    .len_we      (len_we),
    .len_val     (len_val),
    .state       (state),
    .progress    (progress),
    .accept_pulse(accept_pulse),
    .reject_pulse(reject_pulse),
    .fail_count  (fail_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic expect_ev(input bit acc, input int p, input int f);
    exp_t e;
    e.acc  = acc;
    e.prog = p;
    e.fail = f;
    sb_q.push_back(e);
  endtask

  // Press then release key k; returns once the resulting state has settled.
  task automatic rel(input int k);
    @(negedge clk) keys[k] = 1'b1;
    @(negedge clk) keys[k] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic rel2(input int a, input int b);
    @(negedge clk) begin keys[a] = 1'b1; keys[b] = 1'b1; end
    @(negedge clk) begin keys[a] = 1'b0; keys[b] = 1'b0; end
    repeat (3) @(negedge clk);
  endtask

  task automatic prog(input int a, input int k);
    @(negedge clk) begin prog_we = 1'b1; prog_addr = 4'(a); prog_key = 2'(k); end
    @(negedge clk) prog_we = 1'b0;
  endtask

  task automatic set_len(input int v);
    @(negedge clk) begin len_we = 1'b1; len_val = 5'(v); end
    @(negedge clk) len_we = 1'b0;
  endtask

  task automatic chk_sp(input string tag, input int st, input int p);
    chk({tag, "_state"}, 32'(state), st);
    chk({tag, "_progress"}, 32'(progress), p);
  endtask

  // Scoreboard side: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (accept_pulse || reject_pulse) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_pulse", 32'({accept_pulse, reject_pulse}), 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_kind", 32'({accept_pulse, reject_pulse}), e.acc ? 2 : 1);
        chk("sb_state", 32'(state), e.acc ? 2 : 3);
        chk("sb_progress", 32'(progress), e.prog);
        chk("sb_fail", 32'(fail_count), e.fail);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_ = 1'b0; keys = '0; prog_we = 1'b0; prog_addr = '0; prog_key = '0;
    len_we = 1'b0; len_val = '0;
    #3;
    chk_sp("reset", 0, 0);
    chk("reset_fail", 32'(fail_count), 0);
    chk("reset_pulses", 32'({accept_pulse, reject_pulse}), 0);
    @(negedge clk); @(negedge clk) reset_ = 1'b1;

    // len = 0: input ignored
    rel(0);
    chk_sp("len0_ignore", 0, 0);

    // Program 8-key code and walk it
    set_len(8);
    for (int i = 0; i < 8; i++) prog(i, code[i]);
    rel(1);
    chk_sp("idle_wrong_key", 0, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) expect_ev(1'b1, 8, 0);
      rel(code[i]);
      chk_sp("walk", (i == 7) ? 2 : 1, i + 1);
    end
    rel(2);
    chk_sp("accept_to_idle", 0, 0);

    // Wrong key after three correct
    rel(0); rel(0); rel(1);
    expect_ev(1'b0, 3, 1);
    rel(3);
    chk_sp("wrong_key", 3, 3);
    chk("wrong_key_fail", 32'(fail_count), 1);
    rel(2);
    chk_sp("reject_to_idle", 0, 0);

    // Multi-release in MATCH
    rel(0);
    expect_ev(1'b0, 1, 2);
    rel2(0, 1);
    chk_sp("multi", 3, 1);
    rel(1);
    chk_sp("multi_to_idle", 0, 0);

    // Release landing in the cycle the timeout counter saturates advances
    @(negedge clk) keys[0] = 1'b1;
    @(negedge clk) keys[0] = 1'b0;
    repeat (2) @(negedge clk);
    keys[0] = 1'b1;
    repeat (14) @(negedge clk);
    keys[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk_sp("to_release_wins", 1, 2);
    expect_ev(1'b0, 2, 3);
    repeat (20) @(negedge clk);
    chk("to_after_release", 32'(state), 3);
    rel(0);

    // Pure timeout: still MATCH with counter at all ones, REJECT one cycle later
    @(negedge clk) keys[0] = 1'b1;
    @(negedge clk) keys[0] = 1'b0;
    expect_ev(1'b0, 1, 4);
    repeat (17) @(negedge clk);
    chk("to_before", 32'(state), 1);
    @(negedge clk);
    chk("to_fire", 32'(state), 3);
    rel(0);
    chk_sp("to_to_idle", 0, 0);

    // Writes in MATCH are ignored
    rel(0);
    prog(1, 3);
    set_len(1);
    rel(0);
    chk_sp("we_in_match", 1, 2);
    for (int i = 2; i < 7; i++) rel(code[i]);
    expect_ev(1'b1, 8, 0);
    rel(code[7]);
    chk_sp("we_in_match_accept", 2, 8);
    chk("accept_clears_fail", 32'(fail_count), 0);
    rel(0);

    // Write coinciding with IDLE->MATCH still lands
    @(negedge clk) keys[0] = 1'b1;
    @(negedge clk) keys[0] = 1'b0;
    @(negedge clk) begin prog_we = 1'b1; prog_addr = 4'd1; prog_key = 2'd3; end
    @(negedge clk) prog_we = 1'b0;
    chk_sp("wr_on_entry", 1, 1);
    rel(3);
    chk_sp("wr_on_entry_used", 1, 2);
    expect_ev(1'b0, 2, 1);
    rel(3);
    rel(0);
    prog(1, 0);

    // len_val above MAX_LEN clamps to 16
    set_len(31);
    for (int i = 8; i < 16; i++) prog(i, code[i]);
    for (int i = 0; i < 15; i++) begin
      if (i == 7 || i == 14) begin
        rel(code[i]);
        chk_sp("clamp_mid", 1, i + 1);
      end else begin
        rel(code[i]);
      end
    end
    expect_ev(1'b1, 16, 0);
    rel(code[15]);
    chk_sp("clamp_accept", 2, 16);
    rel(0);
    set_len(8);

    // Saturating fail counter
    for (int i = 0; i < 16; i++) begin
      rel(0);
      expect_ev(1'b0, 1, (i + 1 > 15) ? 15 : i + 1);
      rel(3);
      rel(3);
    end
    chk("fail_saturated", 32'(fail_count), 15);
    set_len(1);
    expect_ev(1'b1, 1, 0);
    rel(0);
    chk_sp("len1_accept", 2, 1);
    chk("sat_cleared", 32'(fail_count), 0);
    rel(0);
    set_len(8);

    // Asynchronous reset mid-MATCH
    rel(0);
    expect_ev(1'b0, 1, 1);
    rel(3);
    rel(0);
    rel(0); rel(0);
    chk_sp("pre_reset", 1, 2);
    #2 reset_ = 1'b0;
    #1;
    chk_sp("async_reset", 0, 0);
    chk("async_reset_fail", 32'(fail_count), 0);
    chk("async_reset_pulses", 32'({accept_pulse, reject_pulse}), 0);
    @(negedge clk) reset_ = 1'b1;
    rel(0);
    chk_sp("post_reset_len0", 0, 0);

    // Sequence memory was cleared: code is now 0,0,0
    set_len(3);
    rel(0); rel(0);
    expect_ev(1'b1, 3, 0);
    rel(0);
    chk_sp("post_reset_seq", 2, 3);

    repeat (5) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
